// File: rtl/clock_gate_controller_if.sv
// rtl/clock_gate_controller_if.sv - stop/resume handshake bundle between host/core sources and the clock gate controller
//   stop_req     : NUM_SRC level stop requests, held by each source until serviced
//   host_stop    : level stop request from the host
//   resume_valid : host resume request
//   resume_ready : controller can accept a resume this cycle
//   master drives requests; slave (controller) returns resume_ready
interface clock_gate_controller_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] stop_req;
  logic               host_stop;
  logic               resume_valid;
  logic               resume_ready;

  modport master (
    output stop_req,
    output host_stop,
    output resume_valid,
    input  resume_ready
  );

  modport slave (
    input  stop_req,
    input  host_stop,
    input  resume_valid,
    output resume_ready
  );
endinterface

// File: rtl/clock_gate_controller.sv
// rtl/clock_gate_controller.sv - registered glitch-free active-low clock enable with drain/resume sequencing
//   clock         : base (ungated) clock
//   reset         : asynchronous active-low reset
//   ctl           : stop/resume handshake (slave side)
//   clock_ce_n    : clock buffer CE, 0 = run, 1 = gate, straight from a flop
//   gated         : 1 while in GATED
//   cause         : latched stop causes, bit NUM_SRC = host
//   gated_cycles  : saturating count of cycles with clock_ce_n = 1
//   stop_count    : saturating count of accepted stop events
//   counter_clear : synchronous clear of both counters
module clock_gate_controller #(
  parameter int NUM_SRC       = 4,
  parameter int DRAIN_CYCLES  = 4,
  parameter int RESUME_CYCLES = 8,
  parameter int CNT_W         = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  clock_gate_controller_if.slave ctl,
  output logic                  clock_ce_n,
  output logic                  gated,
  output logic [NUM_SRC:0]      cause,
  output logic [CNT_W-1:0]      gated_cycles,
  output logic [15:0]           stop_count,
  input  logic                  counter_clear
);

  localparam int TMAX = (DRAIN_CYCLES > RESUME_CYCLES) ? DRAIN_CYCLES : RESUME_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    RESUMING = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2,
    GATED    = 2'd3
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [NUM_SRC:0] req;
  logic            any_stop;
  logic            blocked;
  logic            resume_ok;

  assign req      = {ctl.host_stop, ctl.stop_req};
  assign any_stop = |req;

  // Resume waits until every source that caused the stop has let go;
  // the host bit only blocks when the host itself is a recorded cause.
  assign blocked   = (|(cause[NUM_SRC-1:0] & ctl.stop_req)) | (cause[NUM_SRC] & ctl.host_stop);
  assign resume_ok = (state == GATED) && !blocked;
  assign ctl.resume_ready = resume_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RESUMING;
      timer        <= TW'(RESUME_CYCLES - 1);
      clock_ce_n   <= 1'b1;
      gated        <= 1'b0;
      cause        <= '0;
      gated_cycles <= '0;
      stop_count   <= '0;
    end else begin
      // Counts the registered CE, so the cycle CE falls is still counted.
      if (counter_clear) begin
        gated_cycles <= '0;
      end else if (clock_ce_n && (gated_cycles != '1)) begin
        gated_cycles <= gated_cycles + 1'b1;
      end

      if (counter_clear) begin
        stop_count <= '0;
      end else if ((state == RUNNING) && any_stop && (stop_count != 16'hFFFF)) begin
        stop_count <= stop_count + 1'b1;
      end

      case (state)
        RESUMING: begin
          if (timer == '0) begin
            state      <= RUNNING;
            clock_ce_n <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        RUNNING: begin
          if (any_stop) begin
            cause <= req;
            timer <= TW'(DRAIN_CYCLES - 1);
            state <= DRAINING;
          end
        end

        DRAINING: begin
          // Once accepted, a stop always completes even if requests drop.
          cause <= cause | req;
          if (timer == '0) begin
            state      <= GATED;
            clock_ce_n <= 1'b1;
            gated      <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        GATED: begin
          if (ctl.resume_valid && resume_ok) begin
            cause <= '0;
            timer <= TW'(RESUME_CYCLES - 1);
            gated <= 1'b0;
            state <= RESUMING;
          end else begin
            cause <= cause | req;
          end
        end

        default: begin
          state      <= RESUMING;
          timer      <= TW'(RESUME_CYCLES - 1);
          clock_ce_n <= 1'b1;
          gated      <= 1'b0;
          cause      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gate_controller.sv
// tb/tb_clock_gate_controller.sv - directed self-checking bench for clock_gate_controller
module tb_clock_gate_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clock_gate_controller_if #(.NUM_SRC(4)) bus0 ();
  clock_gate_controller_if #(.NUM_SRC(4)) bus1 ();

  logic        ce0, gated0, clr0;
  logic [4:0]  cause0;
  logic [31:0] gcyc0;
  logic [15:0] scnt0;

  logic        ce1, gated1, clr1;
  logic [4:0]  cause1;
  logic [3:0]  gcyc1;
  logic [15:0] scnt1;

  clock_gate_controller u0 (
    .clock         (clock),
    .reset         (reset),
    .ctl           (bus0.slave),
    .clock_ce_n    (ce0),
    .gated         (gated0),
    .cause         (cause0),
    .gated_cycles  (gcyc0),
    .stop_count    (scnt0),
    .counter_clear (clr0)
  );

  clock_gate_controller #(.CNT_W(4)) u1 (
    .clock         (clock),
    .reset         (reset),
    .ctl           (bus1.slave),
    .clock_ce_n    (ce1),
    .gated         (gated1),
    .cause         (cause1),
    .gated_cycles  (gcyc1),
    .stop_count    (scnt1),
    .counter_clear (clr1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge with reset held low; releases it and checks the settle window.
  task automatic recover(input string tag);
    reset = 1'b1;
    check({tag, " ce before edge1"}, 32'(ce0), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check($sformatf("%s ce edge%0d", tag, k), 32'(ce0), (k < 8) ? 32'd1 : 32'd0);
    end
    check({tag, " gated_cycles"}, gcyc0, 32'd8);
    check({tag, " stop_count"}, 32'(scnt0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.stop_req = '0; bus0.host_stop = 1'b0; bus0.resume_valid = 1'b0;
    bus1.stop_req = 4'b0001; bus1.host_stop = 1'b0; bus1.resume_valid = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    #1 reset = 1'b0;
    step(2);

    check("rst ce", 32'(ce0), 32'd1);
    check("rst cause", 32'(cause0), 32'd0);
    check("rst gcyc", gcyc0, 32'd0);
    check("rst scnt", 32'(scnt0), 32'd0);
    check("rst ready", 32'(bus0.resume_ready), 32'd0);
    check("rst gated", 32'(gated0), 32'd0);

    recover("boot");

    // single-cycle stop pulse on source 1
    bus0.stop_req = 4'b0010;
    step(1);
    bus0.stop_req = 4'b0000;
    for (int j = 1; j <= 5; j++) begin
      check($sformatf("pulse ce +%0d", j), 32'(ce0), (j == 5) ? 32'd1 : 32'd0);
      if (j < 5) step(1);
    end
    check("pulse cause", 32'(cause0), 32'h02);
    check("pulse scnt", 32'(scnt0), 32'd1);
    check("pulse gated", 32'(gated0), 32'd1);
    check("pulse ready", 32'(bus0.resume_ready), 32'd1);
    bus0.resume_valid = 1'b1;
    step(1);
    bus0.resume_valid = 1'b0;
    check("pulse resumed gated", 32'(gated0), 32'd0);
    check("pulse resumed cause", 32'(cause0), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check($sformatf("resume ce +%0d", j), 32'(ce0), (j < 8) ? 32'd1 : 32'd0);
    end
    check("pulse gcyc", gcyc0, 32'd17);

    // held source blocks a continuously asserted resume
    bus0.stop_req = 4'b0001;
    bus0.resume_valid = 1'b1;
    step(5);
    check("held ce", 32'(ce0), 32'd1);
    step(3);
    check("held ready", 32'(bus0.resume_ready), 32'd0);
    check("held still gated", 32'(ce0), 32'd1);
    check("held cause", 32'(cause0), 32'h01);
    bus0.stop_req = 4'b0000;
    #1;
    check("held drop ready", 32'(bus0.resume_ready), 32'd1);
    step(1);
    bus0.resume_valid = 1'b0;
    check("held accepted", 32'(gated0), 32'd0);
    step(8);
    check("held ce run", 32'(ce0), 32'd0);
    check("held scnt", 32'(scnt0), 32'd2);

    // host joins a drain started by source 3
    bus0.stop_req = 4'b1000;
    step(1);
    bus0.host_stop = 1'b1;
    step(4);
    check("host ce", 32'(ce0), 32'd1);
    check("host cause", 32'(cause0), 32'h18);
    check("host scnt", 32'(scnt0), 32'd3);
    bus0.resume_valid = 1'b1;
    step(2);
    check("host blk both", 32'(gated0), 32'd1);
    bus0.stop_req = 4'b0000;
    #1;
    check("host blk ready", 32'(bus0.resume_ready), 32'd0);
    step(1);
    check("host blk gated", 32'(gated0), 32'd1);
    bus0.host_stop = 1'b0;
    #1;
    check("host free ready", 32'(bus0.resume_ready), 32'd1);
    step(1);
    bus0.resume_valid = 1'b0;
    check("host resumed", 32'(gated0), 32'd0);

    // requests during RESUMING are ignored until RUNNING has lasted a cycle
    bus0.stop_req = 4'b0100;
    step(8);
    check("ign ce", 32'(ce0), 32'd0);
    check("ign scnt", 32'(scnt0), 32'd3);
    check("ign cause", 32'(cause0), 32'd0);
    step(1);
    check("ign accepted scnt", 32'(scnt0), 32'd4);
    check("ign accepted cause", 32'(cause0), 32'h04);
    step(4);
    check("ign gated ce", 32'(ce0), 32'd1);
    bus0.stop_req = 4'b0000;

    // async reset mid-cycle while gated
    #2 reset = 1'b0;
    #1;
    check("async ce", 32'(ce0), 32'd1);
    check("async cause", 32'(cause0), 32'd0);
    check("async gcyc", gcyc0, 32'd0);
    check("async scnt", 32'(scnt0), 32'd0);
    check("async gated", 32'(gated0), 32'd0);
    step(1);
    recover("recov");

    // CNT_W=4 instance: stop held from reset, counter saturates
    check("sat ce run", 32'(ce1), 32'd0);
    check("sat gcyc8", 32'(gcyc1), 32'd8);
    step(5);
    check("sat ce gated", 32'(ce1), 32'd1);
    check("sat scnt", 32'(scnt1), 32'd1);
    step(7);
    check("sat gcyc15", 32'(gcyc1), 32'd15);
    step(10);
    check("sat gcyc hold", 32'(gcyc1), 32'd15);
    clr1 = 1'b1;
    step(1);
    clr1 = 1'b0;
    check("clr gcyc", 32'(gcyc1), 32'd0);
    check("clr scnt", 32'(scnt1), 32'd0);
    step(1);
    check("clr regrow", 32'(gcyc1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
